// File: rtl/div_freq_prog.sv
// rtl/div_freq_prog.sv - programmable clock divider with glitch-free period/high-time reload
// Optional DIV_FREQ_PROG_SYNC_EN adds a SYNC input that forces a period restart.
module div_freq_prog #(
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = 10
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV_IN,
  input  logic [WIDTH-1:0] HIGH_IN,
  input  logic             LOAD,
`ifdef DIV_FREQ_PROG_SYNC_EN
  input  logic             SYNC,
`endif
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             LOAD_ACK
);

  localparam logic [WIDTH-1:0] DEF_N   = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] DEF_H   = WIDTH'(DEF_DIV / 2);
  localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEF_DIV - 1);
  localparam logic [WIDTH-1:0] MIN_N   = WIDTH'(2);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] high_r;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] pend_high;
  logic [WIDTH-1:0] cap_div;
  logic [WIDTH-1:0] cap_high;
  logic [WIDTH-1:0] cnt_inc;
  logic             force_wrap;
  logic             wrap;

  // Sanitise requests so every captured setting yields a legal, non-runt waveform.
  always_comb begin
    cap_div  = (DIV_IN < MIN_N) ? MIN_N : DIV_IN;
    cap_high = HIGH_IN;
    if (HIGH_IN == '0 || HIGH_IN >= cap_div)
      cap_high = cap_div >> 1;
  end

`ifdef DIV_FREQ_PROG_SYNC_EN
  assign force_wrap = SYNC;
`else
  assign force_wrap = 1'b0;
`endif

  assign cnt_inc = cnt + 1'b1;
  assign wrap    = force_wrap | (EN & (cnt == div_r - 1'b1));

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state     <= ST_RUN;
      cnt       <= DEF_CNT;
      div_r     <= DEF_N;
      high_r    <= DEF_H;
      pend_div  <= DEF_N;
      pend_high <= DEF_H;
      CLK_OUT   <= 1'b0;
      TICK      <= 1'b0;
      LOAD_ACK  <= 1'b0;
    end else begin
      TICK     <= 1'b0;
      LOAD_ACK <= 1'b0;
      if (wrap) begin
        cnt     <= '0;
        TICK    <= 1'b1;
        CLK_OUT <= 1'b1;
        // A LOAD coinciding with the wrap replaces the pending values and waits one more period.
        if (state == ST_PEND && !LOAD) begin
          div_r    <= pend_div;
          high_r   <= pend_high;
          LOAD_ACK <= 1'b1;
          state    <= ST_RUN;
        end
      end else if (EN) begin
        cnt     <= cnt_inc;
        CLK_OUT <= (cnt_inc < high_r);
      end
      if (LOAD) begin
        pend_div  <= cap_div;
        pend_high <= cap_high;
        state     <= ST_PEND;
      end
    end
  end

endmodule

// File: doc/div_freq_prog.md
DIV_FREQ_PROG -- requirements
Module: div_freq_prog

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the period and high-time counters and settings.
REQ-002 Parameter DEF_DIV, default 10: period in CLK_IN cycles after reset; legal range 2..2^WIDTH-1.
REQ-003 CLK_IN  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_IN  input  1  asynchronous, active-high reset.
REQ-005 EN  input  1  count enable; low freezes the divider.
REQ-006 DIV_IN  input  WIDTH  requested period N, in CLK_IN cycles.
REQ-007 HIGH_IN  input  WIDTH  requested high time H, in CLK_IN cycles.
REQ-008 LOAD  input  1  single-cycle strobe that captures DIV_IN and HIGH_IN.
REQ-009 CLK_OUT  output  1  registered divided clock.
REQ-010 TICK  output  1  one-cycle pulse on the first cycle of each period.
REQ-011 LOAD_ACK  output  1  one-cycle pulse on the edge where captured settings take effect.

Function
REQ-012 Active settings div_r and high_r; counter cnt runs 0..div_r-1 and wraps to 0.
REQ-013 Enabled edge with cnt==div_r-1: cnt<=0, TICK<=1, CLK_OUT<=1.
REQ-014 Enabled edge otherwise: cnt<=cnt+1, TICK<=0, CLK_OUT<=(cnt+1 < high_r).
REQ-015 Result: CLK_OUT high exactly high_r cycles and low div_r-high_r cycles per period, with no glitch or runt pulse.
REQ-016 EN low: cnt and CLK_OUT hold; TICK=0; LOAD still captured and held pending.
REQ-017 Capture sanitising: DIV_IN<2 -> N=2; HIGH_IN==0 or HIGH_IN>=N -> H=N>>1 (floor).
REQ-018 Control FSM states:
- RUN: no load pending.
- PEND: captured settings waiting.
REQ-019 LOAD in RUN -> PEND. LOAD in PEND overwrites the captured values; last LOAD wins.
REQ-020 In PEND, the next wrap edge (REQ-013) copies the captured values to div_r/high_r, pulses LOAD_ACK, returns to RUN, and sets CLK_OUT from the new high_r.
REQ-021 LOAD on the same edge as a wrap: values are captured only; they apply at the following wrap, never mid-period.
REQ-022 Counter arithmetic is WIDTH bits and never overflows, because cnt<=div_r-1<=2^WIDTH-2.

Reset
REQ-023 RST_IN high asynchronously forces the following, holding them while asserted:
- cnt=DEF_DIV-1, div_r=DEF_DIV, high_r=DEF_DIV>>1
- CLK_OUT=0, TICK=0, LOAD_ACK=0
- FSM=RUN; pending load discarded
REQ-024 First enabled edge after reset release is a wrap: TICK=1, CLK_OUT=1.
REQ-025 Reset mid-period or while in PEND aborts immediately; no LOAD_ACK is issued for the discarded load.

Configuration
REQ-026 Macro DIV_FREQ_PROG_SYNC_EN defined: adds input port SYNC (1 bit).
- SYNC high on an edge forces a wrap (REQ-013/REQ-020) regardless of cnt.
- SYNC acts even when EN is low.
- SYNC has priority over normal counting.
REQ-027 Macro undefined: SYNC port and its logic are absent; behaviour is REQ-012..REQ-025 only.

Verification
REQ-028 Reset, EN=1, defaults -> CLK_OUT period 10 cycles, 5 high / 5 low; TICK once per 10 cycles on the rising edge of CLK_OUT.
REQ-029 LOAD DIV_IN=7, HIGH_IN=2 at cnt=3 -> old 10-cycle period completes; LOAD_ACK and TICK on the same edge; then 2 high / 5 low.
REQ-030 LOAD DIV_IN=1, HIGH_IN=0 -> applied as N=2, H=1: CLK_OUT toggles every cycle. LOAD DIV_IN=8, HIGH_IN=9 -> 4 high / 4 low.
REQ-031 Two LOADs in PEND (N=6, then N=12, H=3) -> only N=12/H=3 applied; exactly one LOAD_ACK.
REQ-032 EN low for 5 cycles mid-high phase -> CLK_OUT frozen high, TICK=0; remaining high count resumes unchanged after EN rises.
REQ-033 RST_IN pulsed mid-cycle while PEND -> outputs 0 asynchronously; no LOAD_ACK; defaults resume. With DIV_FREQ_PROG_SYNC_EN, SYNC at cnt=4 -> TICK next edge, new period starts.
